// File: rtl/tt_pin_exerciser_pkg.sv
// Shared types and constants for the pin exerciser: modes, FSM states, LFSR/MISR taps, rotate helper.
// Combinational definitions only; no latency and no backpressure.
package tt_exerciser_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Fibonacci tap masks (bit n-1 set for tap n) of maximal-length polynomials.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] misr_poly(input int w);
        case (w)
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return lfsr_taps(w);
        endcase
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int w, input int n);
        logic [31:0] r;
        logic [4:0]  idx;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                idx    = 5'((i + n) % w);
                r[idx] = v[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_pin_exerciser_if.sv
// Pin bundle between exerciser, user DUT and golden model (stimulus out, DUT/reference outputs in).
// Plain wires: no latency, no backpressure.
interface tt_pin_exerciser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] stim_ui;
    logic [WIDTH-1:0] stim_uio;
    logic [WIDTH-1:0] dut_uo;
    logic [WIDTH-1:0] dut_uio_out;
    logic [WIDTH-1:0] dut_uio_oe;
    logic [WIDTH-1:0] ref_uo;
    logic [WIDTH-1:0] ref_uio_out;
    logic [WIDTH-1:0] ref_uio_oe;

    modport master (
        output stim_ui, stim_uio,
        input  dut_uo, dut_uio_out, dut_uio_oe, ref_uo, ref_uio_out, ref_uio_oe
    );

    modport slave (
        input  stim_ui, stim_uio,
        output dut_uo, dut_uio_out, dut_uio_oe, ref_uo, ref_uio_out, ref_uio_oe
    );
endinterface

// File: rtl/tt_stim_gen.sv
// Pattern generator: load captures mode/seed and emits the first vector, advance steps the pattern.
// Vector registered, one cycle after load/advance; no backpressure (caller holds by not advancing).
module tt_stim_gen
    import tt_exerciser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] vec_o
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] vec_q, vec_d;

    always_comb begin
        mode_d = mode_q;
        vec_d  = vec_q;
        if (load_i) begin
            mode_d = mode_i;
            case (mode_i)
                MODE_WALK: vec_d = WIDTH'(1);
                // An all-zero LFSR would lock up, so a zero seed starts at 1.
                MODE_LFSR: vec_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
                default:   vec_d = seed_i;
            endcase
        end else if (advance_i) begin
            case (mode_q)
                MODE_COUNT: vec_d = vec_q + WIDTH'(1);
                MODE_WALK:  vec_d = WIDTH'(rotl(32'(vec_q), WIDTH, 1));
                MODE_LFSR:  vec_d = {vec_q[WIDTH-2:0], ^(vec_q & TAPS)};
                default:    vec_d = vec_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_COUNT;
            vec_q  <= '0;
        end else begin
            mode_q <= mode_d;
            vec_q  <= vec_d;
        end
    end

    assign vec_o = vec_q;
endmodule

// File: rtl/tt_pin_exerciser.sv
// Stimulus/response exerciser: vector i driven 1 cycle after start+i, checked LATENCY cycles later; optional MISR via TT_EXERCISER_MISR_EN.
// No backpressure: start is only accepted in IDLE and a run cannot be stalled, only aborted by reset.
module tt_pin_exerciser
    import tt_exerciser_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 8,
    parameter int LATENCY = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic [CNT_W-1:0]     num_vec_i,
    tt_pin_exerciser_if.master   pins,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_count_o,
    output logic [CNT_W-1:0]     first_err_o,
    output logic [2*WIDTH-1:0]   signature_o
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, vec_idx_q, vec_idx_d, cmp_idx_q, cmp_idx_d, first_q, first_d;
    logic [3:0]       lat_q, lat_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             busy, start_ok, run_last, gen_load, gen_adv, cmp_vld, cmp_last, mismatch;
    logic [WIDTH-1:0] vec, stim;

    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign start_ok = (state_q == S_IDLE) && start_i;
    assign run_last = (state_q == S_RUN) && (vec_idx_q == num_q - CNT_W'(1));
    assign gen_load = start_ok && (num_vec_i != '0);
    assign gen_adv  = (state_q == S_RUN) && !run_last;
    // lat_q saturates at LATENCY, so comparing starts exactly LATENCY cycles into the run.
    assign cmp_vld  = busy && (lat_q == LAT);
    assign cmp_last = cmp_vld && (cmp_idx_q == num_q - CNT_W'(1));
    assign mismatch = (pins.dut_uo != pins.ref_uo)
                   || (pins.dut_uio_oe != pins.ref_uio_oe)
                   || ((pins.dut_uio_out & pins.ref_uio_oe) != (pins.ref_uio_out & pins.ref_uio_oe));

    tt_stim_gen #(.WIDTH(WIDTH)) u_stim_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mode_i    (mode_e'(mode_i)),
        .seed_i    (seed_i),
        .load_i    (gen_load),
        .advance_i (gen_adv),
        .vec_o     (vec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (num_vec_i == '0) ? S_DONE : S_RUN;
            S_RUN:   if (run_last) state_d = (LATENCY == 0) ? S_DONE : S_FLUSH;
            S_FLUSH: if (cmp_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_d     = num_q;
        vec_idx_d = vec_idx_q;
        cmp_idx_d = cmp_idx_q;
        lat_d     = lat_q;
        err_d     = err_q;
        first_d   = first_q;
        pass_d    = pass_q;
        if (start_ok) begin
            num_d     = num_vec_i;
            vec_idx_d = '0;
            cmp_idx_d = '0;
            lat_d     = '0;
            err_d     = '0;
            first_d   = '0;
            pass_d    = 1'b0;
        end else begin
            if (gen_adv) vec_idx_d = vec_idx_q + CNT_W'(1);
            if (busy && (lat_q != LAT)) lat_d = lat_q + 4'd1;
            if (cmp_vld) begin
                cmp_idx_d = cmp_idx_q + CNT_W'(1);
                if (mismatch) begin
                    if (err_q == '0) first_d = cmp_idx_q;
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                end
            end
        end
        if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (err_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            vec_idx_q <= '0;
            cmp_idx_q <= '0;
            lat_q     <= '0;
            err_q     <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            vec_idx_q <= vec_idx_d;
            cmp_idx_q <= cmp_idx_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
        end
    end

`ifdef TT_EXERCISER_MISR_EN
    localparam int               SW   = 2 * WIDTH;
    localparam logic [SW-1:0]    POLY = SW'(misr_poly(SW));

    logic [SW-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (start_ok) begin
            sig_d = '1;
        end else if (cmp_vld) begin
            sig_d = {sig_q[SW-2:0], ^(sig_q & POLY)} ^ {pins.dut_uio_out & pins.dut_uio_oe, pins.dut_uo};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sig_q <= '1;
        else       sig_q <= sig_d;
    end

    assign signature_o = sig_q;
`else
    assign signature_o = '0;
`endif

    assign stim          = busy ? vec : '0;
    assign pins.stim_ui  = stim;
    assign pins.stim_uio = WIDTH'(rotl(32'(stim), WIDTH, WIDTH / 2));
    assign busy_o        = busy;
    assign done_o        = (state_q == S_DONE);
    assign pass_o        = pass_q;
    assign err_count_o   = err_q;
    assign first_err_o   = first_q;
endmodule

// File: tb/tb_tt_pin_exerciser.sv
// Directed bench for tt_pin_exerciser: 2-cycle user-DUT model with injectable faults, second instance with ERR_W=2.
module tb_tt_pin_exerciser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  seed = 8'h00;
    logic [15:0] num_vec = 16'd0;
    logic        busy, done, pass, busy2, done2, pass2;
    logic [7:0]  err;
    logic [1:0]  err2;
    logic [15:0] first, first2, sig, sig2;
    int          checks = 0, errors = 0;
    logic        stuck3 = 1'b0, fault_oe = 1'b0;
    logic [7:0]  d1 = 8'h00, d2 = 8'h00, u1 = 8'h00, u2 = 8'h00;

`ifdef TT_EXERCISER_MISR_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    tt_pin_exerciser_if #(.WIDTH(8)) pins ();
    tt_pin_exerciser_if #(.WIDTH(8)) pins2 ();

    tt_pin_exerciser #(.WIDTH(8), .CNT_W(16), .ERR_W(8), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .seed_i(seed), .num_vec_i(num_vec),
        .pins(pins), .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err),
        .first_err_o(first), .signature_o(sig));

    tt_pin_exerciser #(.WIDTH(8), .CNT_W(16), .ERR_W(2), .LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .mode_i(mode), .seed_i(seed), .num_vec_i(num_vec),
        .pins(pins2), .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .first_err_o(first2), .signature_o(sig2));

    always #5 clk = ~clk;

    // User DUT and golden model: two-cycle pipeline, uo = ui | uio, uio_out echoes uio_in on low nibble.
    always @(posedge clk) begin
        d1 <= pins.stim_ui;  d2 <= d1;
        u1 <= pins.stim_uio; u2 <= u1;
    end
    assign pins.ref_uo      = d2 | u2;
    assign pins.ref_uio_out = u2;
    assign pins.ref_uio_oe  = 8'h0F;
    assign pins.dut_uo      = (d2 | u2) & (stuck3 ? 8'hF7 : 8'hFF);
    assign pins.dut_uio_out = u2 ^ 8'hF0;
    assign pins.dut_uio_oe  = fault_oe ? 8'h1F : 8'h0F;
    // Second instance always disagrees with its reference.
    assign pins2.ref_uo      = 8'h00;
    assign pins2.ref_uio_out = 8'h00;
    assign pins2.ref_uio_oe  = 8'h00;
    assign pins2.dut_uo      = 8'hFF;
    assign pins2.dut_uio_out = 8'h00;
    assign pins2.dut_uio_oe  = 8'h00;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sel, input logic [1:0] m, input logic [7:0] s, input logic [15:0] n);
        mode = m; seed = s; num_vec = n;
        if (sel) start2 = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (((sel ? done2 : done) !== 1'b1) && cyc < 600) begin
            tick();
            cyc++;
        end
        if ((sel ? done2 : done) !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_done: no done after %0d cycles, required done=1", cyc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tick(); tick();
        checks += 7;
        if (pins.stim_ui !== 8'h00) begin errors++; $display("FAIL reset_stim_ui: got %h want 00", pins.stim_ui); end
        if (pins.stim_uio !== 8'h00) begin errors++; $display("FAIL reset_stim_uio: got %h want 00", pins.stim_uio); end
        if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
        if (err !== 8'h00) begin errors++; $display("FAIL reset_err: got %0d want 0", err); end
        if (first !== 16'h0) begin errors++; $display("FAIL reset_first: got %0d want 0", first); end
        if (sig !== SIG_RST) begin errors++; $display("FAIL reset_sig: got %h want %h", sig, SIG_RST); end
        if (err2 !== 2'b00) begin errors++; $display("FAIL reset_err2: got %0d want 0", err2); end
        rst = 1'b0; tick();
    endtask

    task automatic test_count;
        logic [7:0] eu [4];
        logic [7:0] euio [4];
        eu   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        euio = '{8'hEF, 8'hFF, 8'h00, 8'h10};
        do_start(1'b0, 2'd0, 8'hFE, 16'd4);
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (pins.stim_ui !== eu[i]) begin errors++; $display("FAIL count_stim_ui[%0d]: got %h want %h", i, pins.stim_ui, eu[i]); end
            if (pins.stim_uio !== euio[i]) begin errors++; $display("FAIL count_stim_uio[%0d]: got %h want %h", i, pins.stim_uio, euio[i]); end
            if (busy !== 1'b1) begin errors++; $display("FAIL count_busy[%0d]: got %b want 1", i, busy); end
            tick();
        end
        tick();
        checks += 2;
        if (pins.stim_ui !== 8'h01) begin errors++; $display("FAIL count_flush_hold: got %h want 01", pins.stim_ui); end
        if (done !== 1'b0) begin errors++; $display("FAIL count_early_done: got %b want 0", done); end
        tick();
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL count_done_t7: got %b want 1", done); end
        if (pass !== 1'b1) begin errors++; $display("FAIL count_pass: got %b want 1", pass); end
        if (err !== 8'd0) begin errors++; $display("FAIL count_err: got %0d want 0", err); end
        tick();
        checks += 2;
        if ({done, pass} !== 2'b01) begin errors++; $display("FAIL count_after_done: got done,pass=%b want 01", {done, pass}); end
        if (pins.stim_ui !== 8'h00) begin errors++; $display("FAIL count_idle_stim: got %h want 00", pins.stim_ui); end
    endtask

    task automatic test_walking;
        int cyc;
        stuck3 = 1'b1;
        do_start(1'b0, 2'd1, 8'hAA, 16'd10);
        wait_done(1'b0, cyc);
        checks += 4;
        if (cyc != 12) begin errors++; $display("FAIL walk_done_time: got %0d want 12", cyc); end
        if (err !== 8'd2) begin errors++; $display("FAIL walk_err: got %0d want 2", err); end
        if (first !== 16'd3) begin errors++; $display("FAIL walk_first: got %0d want 3", first); end
        if (pass !== 1'b0) begin errors++; $display("FAIL walk_pass: got %b want 0", pass); end
        stuck3 = 1'b0;
        tick();
    endtask

    task automatic test_zero_len;
        do_start(1'b0, 2'd0, 8'h55, 16'd0);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        if ({pass, err} !== {1'b1, 8'd0}) begin errors++; $display("FAIL zero_pass: got pass=%b err=%0d want 1/0", pass, err); end
        tick();
        checks++;
        if ({busy, done, pass} !== 3'b001) begin errors++; $display("FAIL zero_after: got %b want 001", {busy, done, pass}); end
    endtask

    task automatic test_start_ignored;
        int cyc;
        do_start(1'b0, 2'd0, 8'h10, 16'd6);
        checks++;
        if (pins.stim_ui !== 8'h10) begin errors++; $display("FAIL busy_start_v0: got %h want 10", pins.stim_ui); end
        tick();
        mode = 2'd3; seed = 8'h80; num_vec = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pins.stim_ui !== 8'h12) begin errors++; $display("FAIL busy_start_index: got %h want 12", pins.stim_ui); end
        wait_done(1'b0, cyc);
        checks += 2;
        if (cyc != 6) begin errors++; $display("FAIL busy_start_done_time: got %0d want 6", cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b want 1", pass); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL done_start_ignored: got busy,done=%b want 00", {busy, done}); end
        if (pins.stim_ui !== 8'h00) begin errors++; $display("FAIL done_start_stim: got %h want 00", pins.stim_ui); end
    endtask

    task automatic test_reset_midrun;
        int cyc, seen;
        do_start(1'b0, 2'd0, 8'h20, 16'd8);
        repeat (5) tick();
        checks++;
        if (pins.stim_ui !== 8'h25) begin errors++; $display("FAIL midrun_v5: got %h want 25", pins.stim_ui); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 4;
        if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL midrun_flags: got %b want 000", {busy, done, pass}); end
        if (pins.stim_ui !== 8'h00) begin errors++; $display("FAIL midrun_stim: got %h want 00", pins.stim_ui); end
        if ({err, first} !== 24'h0) begin errors++; $display("FAIL midrun_counters: got err=%0d first=%0d want 0/0", err, first); end
        if (sig !== SIG_RST) begin errors++; $display("FAIL midrun_sig: got %h want %h", sig, SIG_RST); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles want 0", seen); end
        do_start(1'b0, 2'd0, 8'h30, 16'd3);
        wait_done(1'b0, cyc);
        checks += 2;
        if (cyc != 5) begin errors++; $display("FAIL midrun_rerun_time: got %0d want 5", cyc); end
        if ({pass, err} !== {1'b1, 8'd0}) begin errors++; $display("FAIL midrun_rerun_pass: got pass=%b err=%0d want 1/0", pass, err); end
        tick();
    endtask

    task automatic test_oe_mismatch;
        int cyc;
        fault_oe = 1'b1;
        do_start(1'b0, 2'd3, 8'h33, 16'd3);
        wait_done(1'b0, cyc);
        checks += 2;
        if (cyc != 5) begin errors++; $display("FAIL oe_done_time: got %0d want 5", cyc); end
        if ({err, first, pass} !== {8'd3, 16'd0, 1'b0}) begin
            errors++; $display("FAIL oe_result: got err=%0d first=%0d pass=%b want 3/0/0", err, first, pass);
        end
        fault_oe = 1'b0;
        tick();
    endtask

    task automatic test_saturate;
        int cyc;
        do_start(1'b1, 2'd3, 8'h5A, 16'd9);
        checks++;
        if (pins2.stim_ui !== 8'h5A) begin errors++; $display("FAIL sat_hold_stim: got %h want 5A", pins2.stim_ui); end
        wait_done(1'b1, cyc);
        checks += 4;
        if (cyc != 11) begin errors++; $display("FAIL sat_done_time: got %0d want 11", cyc); end
        if (err2 !== 2'd3) begin errors++; $display("FAIL sat_err: got %0d want 3", err2); end
        if (first2 !== 16'd0) begin errors++; $display("FAIL sat_first: got %0d want 0", first2); end
        if (pass2 !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b want 0", pass2); end
        tick();
    endtask

    task automatic test_lfsr;
        int cyc;
        logic [7:0]  v, r;
        logic [15:0] msig, exp_sig;
        v = 8'h01; msig = 16'hFFFF;
        do_start(1'b0, 2'd2, 8'h00, 16'd255);
        for (int i = 0; i < 255; i++) begin
            checks++;
            if (pins.stim_ui !== v) begin errors++; $display("FAIL lfsr_vec[%0d]: got %h want %h", i, pins.stim_ui, v); end
            r    = {v[3:0], v[7:4]};
            msig = {msig[14:0], ^(msig & 16'hD008)} ^ {r & 8'h0F, v | r};
            v    = {v[6:0], ^(v & 8'hB8)};
            tick();
        end
`ifdef TT_EXERCISER_MISR_EN
        exp_sig = msig;
`else
        exp_sig = 16'h0000;
`endif
        wait_done(1'b0, cyc);
        checks += 3;
        if (cyc != 2) begin errors++; $display("FAIL lfsr_done_time: got %0d want 2", cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL lfsr_pass: got %b want 1", pass); end
        if (sig !== exp_sig) begin errors++; $display("FAIL lfsr_sig: got %h want %h", sig, exp_sig); end
        tick();
        do_start(1'b0, 2'd2, 8'h00, 16'd255);
        wait_done(1'b0, cyc);
        checks += 2;
        if (cyc != 257) begin errors++; $display("FAIL lfsr_rerun_time: got %0d want 257", cyc); end
        if (sig !== exp_sig) begin errors++; $display("FAIL lfsr_rerun_sig: got %h want %h", sig, exp_sig); end
        repeat (3) tick();
        checks++;
        if (sig !== exp_sig) begin errors++; $display("FAIL lfsr_sig_frozen: got %h want %h", sig, exp_sig); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_walking();
        test_zero_len();
        test_start_ignored();
        test_reset_midrun();
        test_oe_mismatch();
        test_saturate();
        test_lfsr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
